// File: rtl/memory_arbiter.sv
// Memory arbiter: muxes one instruction port and one data port onto a single RAM responder.
// Priority is data write > data read > instruction read. Every transaction runs
// IDLE -> REQ -> DONE, with a timeout and a sticky error flag.

package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] BAD     = 32'hBAD1BAD1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        memerr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {NONE, INSTR, DREAD, DWRITE} owner_t;

  // Last REQ-cycle count value before the transaction is abandoned.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_d;
  owner_t      r_owner, w_owner_d;
  logic        r_ramren, w_ramren_d;
  logic        r_ramwen, w_ramwen_d;
  logic [31:0] r_ramaddr, w_ramaddr_d;
  logic [31:0] r_ramstore, w_ramstore_d;
  logic [31:0] r_iload, w_iload_d;
  logic [31:0] r_dload, w_dload_d;
  logic        r_memerr, w_memerr_d;
  logic [7:0]  r_cnt, w_cnt_d;

  logic        w_done_instr;
  logic        w_done_data;

  // State and datapath registers; everything clears immediately on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_owner    <= NONE;
      r_ramren   <= 1'b0;
      r_ramwen   <= 1'b0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_iload    <= '0;
      r_dload    <= '0;
      r_memerr   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_owner    <= w_owner_d;
      r_ramren   <= w_ramren_d;
      r_ramwen   <= w_ramwen_d;
      r_ramaddr  <= w_ramaddr_d;
      r_ramstore <= w_ramstore_d;
      r_iload    <= w_iload_d;
      r_dload    <= w_dload_d;
      r_memerr   <= w_memerr_d;
      r_cnt      <= w_cnt_d;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/abort in REQ, one-cycle DONE.
  always_comb begin
    w_state_d    = r_state;
    w_owner_d    = r_owner;
    w_ramren_d   = r_ramren;
    w_ramwen_d   = r_ramwen;
    w_ramaddr_d  = r_ramaddr;
    w_ramstore_d = r_ramstore;
    w_iload_d    = r_iload;
    w_dload_d    = r_dload;
    w_memerr_d   = r_memerr;
    w_cnt_d      = r_cnt;
    case (r_state)
      IDLE: begin
        // A simultaneous dREN is ignored when dWEN is set.
        if (dWEN) begin
          w_owner_d    = DWRITE;
          w_ramaddr_d  = daddr;
          w_ramstore_d = dstore;
          w_ramren_d   = 1'b0;
          w_ramwen_d   = 1'b1;
        end else if (dREN) begin
          w_owner_d    = DREAD;
          w_ramaddr_d  = daddr;
          w_ramstore_d = '0;
          w_ramren_d   = 1'b1;
          w_ramwen_d   = 1'b0;
        end else if (iREN) begin
          w_owner_d    = INSTR;
          w_ramaddr_d  = iaddr;
          w_ramstore_d = '0;
          w_ramren_d   = 1'b1;
          w_ramwen_d   = 1'b0;
        end
        if (dWEN || dREN || iREN) begin
          w_cnt_d   = '0;
          w_state_d = REQ;
        end
      end
      REQ: begin
        // RAM outputs stay frozen here; the responder restarts latency on any change.
        if (ramstate == ACCESS) begin
          if (r_owner == INSTR) begin
            w_iload_d = ramload;
          end else if (r_owner == DREAD) begin
            w_dload_d = ramload;
          end
          w_ramren_d = 1'b0;
          w_ramwen_d = 1'b0;
          w_state_d  = DONE;
        end else if (ramstate == ERROR || ramstate == FREE || r_cnt == TmoLast) begin
          if (r_owner == INSTR) begin
            w_iload_d = BAD;
          end else if (r_owner == DREAD) begin
            w_dload_d = BAD;
          end
          w_memerr_d = 1'b1;
          w_ramren_d = 1'b0;
          w_ramwen_d = 1'b0;
          w_state_d  = DONE;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      DONE: begin
        w_state_d = IDLE;
        w_owner_d = NONE;
      end
      default: begin
        w_state_d = IDLE;
        w_owner_d = NONE;
      end
    endcase
  end

  assign w_done_instr = (r_state == DONE) && (r_owner == INSTR);
  assign w_done_data  = (r_state == DONE) && ((r_owner == DREAD) || (r_owner == DWRITE));

  assign iwait    = iREN & ~w_done_instr;
  assign dwait    = (dREN | dWEN) & ~w_done_data;
  assign iload    = r_iload;
  assign dload    = r_dload;
  assign ramREN   = r_ramren;
  assign ramWEN   = r_ramwen;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;
  assign memerr   = r_memerr;

endmodule
